sram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port SRAM controller between two independent requesters, such as a video fetch engine and a CPU/UART data path. It accepts word read/write requests on port 0 and port 1, serialises them onto the controller's `mem/rw/addr/data_f2s/ready` command interface and returns read data with a per-port completion pulse. The block sits between the system masters and the SRAM controller; the controller's chip-side pins are untouched.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/sram_arb_pick.sv | 33 +++
 rtl/sram_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM command arbiter.
// Contents: FSM state encoding, port ID constants, default address/data widths.
package sram_arb_pkg;

    localparam int unsigned AW_DEF = 18;
    localparam int unsigned DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } state_t;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select for the SRAM arbiter.
// Ports: p0_req_i/p1_req_i requests, last_i most recent owner, win_c winning port ID.
// Config macro SRAM_ARB_RR_EN: defined -> round-robin on ties, undefined -> port 0 wins ties.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic p0_req_i,
    input  logic p1_req_i,
    input  logic last_i,
    output logic win_c
);

`ifndef SRAM_ARB_RR_EN
    // Fixed priority ignores the history bit.
    logic unused_last;
    assign unused_last = last_i;
`endif

    // Winner is only meaningful when at least one request is high.
    always_comb begin
        win_c = P0;
        if (p0_req_i && p1_req_i) begin
`ifdef SRAM_ARB_RR_EN
            win_c = ~last_i;
`else
            win_c = P0;
`endif
        end else if (p1_req_i) begin
            win_c = P1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single-port SRAM controller command interface between two requesters.
// Ports: clk, reset (async, active-high); per port pN_req/rw/addr/wdata in,
//        pN_ack/done pulses and registered pN_rdata out; controller side
//        mem/rw/addr/data_f2s out, ready/data_s2f in.
// Config macro SRAM_ARB_RR_EN (see sram_arb_pick): round-robin vs fixed priority on ties.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_rw,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic          p0_done,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_rw,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic          p1_done,
    output logic [DW-1:0] p1_rdata,
    output logic          mem,
    output logic          rw,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data_f2s,
    input  logic          ready,
    input  logic [DW-1:0] data_s2f
);

    state_t        state_q;
    logic          owner_q;
    logic          last_q;
    logic          wait_first_q;
    logic          mem_q;
    logic          rw_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          p0_ack_q;
    logic          p1_ack_q;
    logic          p0_done_q;
    logic          p1_done_q;
    logic [DW-1:0] p0_rdata_q;
    logic [DW-1:0] p1_rdata_q;
    logic          win_c;

    sram_arb_pick u_pick (
        .p0_req_i (p0_req),
        .p1_req_i (p1_req),
        .last_i   (last_q),
        .win_c    (win_c)
    );

    // FSM, command latch and read data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= P0;
            last_q       <= P1;
            wait_first_q <= 1'b0;
            mem_q        <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            p0_done_q    <= 1'b0;
            p1_done_q    <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            p0_ack_q  <= 1'b0;
            p1_ack_q  <= 1'b0;
            p0_done_q <= 1'b0;
            p1_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        owner_q <= win_c;
                        last_q  <= win_c;
                        mem_q   <= 1'b1;
                        state_q <= ISSUE;
                        if (win_c == P1) begin
                            rw_q     <= p1_rw;
                            addr_q   <= p1_addr;
                            wdata_q  <= p1_wdata;
                            p1_ack_q <= 1'b1;
                        end else begin
                            rw_q     <= p0_rw;
                            addr_q   <= p0_addr;
                            wdata_q  <= p0_wdata;
                            p0_ack_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // Strobe stays high until the controller takes the command.
                    if (ready) begin
                        mem_q        <= 1'b0;
                        wait_first_q <= 1'b1;
                        state_q      <= WAIT;
                    end
                end
                WAIT: begin
                    // ready is still high in the first cycle after acceptance; skip it.
                    wait_first_q <= 1'b0;
                    if (!wait_first_q && ready) begin
                        state_q <= IDLE;
                        if (owner_q == P1) begin
                            p1_done_q <= 1'b1;
                            if (rw_q) p1_rdata_q <= data_s2f;
                        end else begin
                            p0_done_q <= 1'b1;
                            if (rw_q) p0_rdata_q <= data_s2f;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem      = mem_q;
    assign rw       = rw_q;
    assign addr     = addr_q;
    assign data_f2s = wdata_q;
    assign p0_ack   = p0_ack_q;
    assign p1_ack   = p1_ack_q;
    assign p0_done  = p0_done_q;
    assign p1_done  = p1_done_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a small SRAM controller model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 1'b0, p0_rw = 1'b0;
    logic [17:0] p0_addr = '0;
    logic [15:0] p0_wdata = '0;
    logic        p1_req = 1'b0, p1_rw = 1'b0;
    logic [17:0] p1_addr = '0;
    logic [15:0] p1_wdata = '0;
    logic        p0_ack, p0_done, p1_ack, p1_done;
    logic [15:0] p0_rdata, p1_rdata;
    logic        mem, rw;
    logic [17:0] addr;
    logic [15:0] data_f2s;
    logic        ready;
    logic [15:0] data_s2f;

    int checks = 0;
    int passes = 0;

`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    sram_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem(mem), .rw(rw), .addr(addr), .data_f2s(data_f2s),
        .ready(ready), .data_s2f(data_s2f)
    );

    always #5 clk = ~clk;

    // Controller model: accepts on mem&&ready, busy two cycles, ready returns with data.
    logic [15:0] sram_m [16] = '{0: 16'hBEEF, default: 16'h0000};
    logic [1:0]  busy;
    logic [3:0]  m_addr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ready    <= 1'b1;
            busy     <= 2'd0;
            m_addr   <= 4'd0;
            data_s2f <= 16'h0;
        end else if (mem && ready) begin
            ready  <= 1'b0;
            busy   <= 2'd2;
            m_addr <= addr[3:0];
            if (!rw) sram_m[addr[3:0]] <= data_f2s;
        end else if (busy != 2'd0) begin
            busy <= busy - 2'd1;
            if (busy == 2'd1) begin
                ready    <= 1'b1;
                data_s2f <= sram_m[m_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem"},      32'(mem), 32'h0);
        check({tag, "_acks"},     32'({p0_ack, p1_ack}), 32'h0);
        check({tag, "_dones"},    32'({p0_done, p1_done}), 32'h0);
        check({tag, "_rw"},       32'(rw), 32'h0);
        check({tag, "_addr"},     32'(addr), 32'h0);
        check({tag, "_data_f2s"}, 32'(data_f2s), 32'h0);
        check({tag, "_p0_rdata"}, 32'(p0_rdata), 32'h0);
        check({tag, "_p1_rdata"}, 32'(p1_rdata), 32'h0);
    endtask

    int  n_grants;
    int  saw_done;
    bit  both_ack;
    logic order [6];

    initial begin
        // Reset state
        cyc(2);
        check_idle_outputs("reset");
        reset = 1'b0;
        cyc(1);

        // Single p0 read at 0x00010
        p0_req = 1'b1; p0_rw = 1'b1; p0_addr = 18'h00010;
        cyc(1);                                   // N+1
        check("rd_p0_ack",  32'(p0_ack), 32'h1);
        check("rd_mem_n1",  32'(mem), 32'h1);
        check("rd_addr",    32'(addr), 32'h10);
        check("rd_rw",      32'(rw), 32'h1);
        check("rd_p1_ack",  32'(p1_ack), 32'h0);
        p0_req = 1'b0;
        cyc(1);                                   // N+2
        check("rd_mem_n2",  32'(mem), 32'h0);
        check("rd_ack_n2",  32'(p0_ack), 32'h0);
        cyc(2);                                   // N+4
        check("rd_done_n4", 32'(p0_done), 32'h0);
        cyc(1);                                   // N+5
        check("rd_done_n5", 32'(p0_done), 32'h1);
        check("rd_rdata",   32'(p0_rdata), 32'hBEEF);
        check("rd_p1_done", 32'(p1_done), 32'h0);
        cyc(1);
        check("rd_done_n6", 32'(p0_done), 32'h0);

        // p1 write 0x1234 to 0x3FFFF, then read back with req held
        p1_req = 1'b1; p1_rw = 1'b0; p1_addr = 18'h3FFFF; p1_wdata = 16'h1234;
        cyc(1);                                   // N+1
        check("wr_p1_ack",  32'(p1_ack), 32'h1);
        check("wr_rw",      32'(rw), 32'h0);
        check("wr_data_is", 32'(data_f2s), 32'h1234);
        p1_rw = 1'b1;
        cyc(1);                                   // N+2
        check("wr_data_wt", 32'(data_f2s), 32'h1234);
        cyc(3);                                   // N+5
        check("wr_done",    32'(p1_done), 32'h1);
        cyc(1);                                   // N+6
        check("rb_p1_ack",  32'(p1_ack), 32'h1);
        p1_req = 1'b0;
        cyc(4);                                   // N+10
        check("rb_done",    32'(p1_done), 32'h1);
        check("rb_rdata",   32'(p1_rdata), 32'h1234);
        check("rb_p0_keep", 32'(p0_rdata), 32'hBEEF);

        // p1 read; p0 requests in the cycle p1_done is high
        p1_req = 1'b1; p1_rw = 1'b1; p1_addr = 18'h00010;
        cyc(1);
        p1_req = 1'b0;
        cyc(4);
        check("sd_p1_done", 32'(p1_done), 32'h1);
        p0_req = 1'b1; p0_rw = 1'b1; p0_addr = 18'h3FFFF;
        cyc(1);
        check("sd_p0_ack",  32'(p0_ack), 32'h1);
        check("sd_mem",     32'(mem), 32'h1);
        p0_req = 1'b0;
        cyc(4);
        check("sd_p0_done", 32'(p0_done), 32'h1);
        check("sd_p0_data", 32'(p0_rdata), 32'h1234);

        // Reset during WAIT of a p0 read
        p0_req = 1'b1; p0_rw = 1'b1; p0_addr = 18'h00010;
        cyc(1);
        p0_req = 1'b0;
        cyc(1);                                   // WAIT
        reset = 1'b1;
        #1;
        check_idle_outputs("midrst");
        cyc(1);
        reset = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (p0_done) saw_done++;
        end
        check("midrst_no_done", 32'(saw_done), 32'h0);
        p1_req = 1'b1; p1_rw = 1'b1; p1_addr = 18'h00010;
        cyc(1);
        check("post_p1_ack", 32'(p1_ack), 32'h1);
        p1_req = 1'b0;
        cyc(4);
        check("post_p1_done", 32'(p1_done), 32'h1);
        check("post_p1_data", 32'(p1_rdata), 32'hBEEF);

        // Continuous contention for six grants (last owner is p1 here)
        p0_req = 1'b1; p0_rw = 1'b1; p0_addr = 18'h00010;
        p1_req = 1'b1; p1_rw = 1'b1; p1_addr = 18'h3FFFF;
        n_grants = 0;
        both_ack = 1'b0;
        for (int c = 0; c < 60 && n_grants < 6; c++) begin
            cyc(1);
            if (p0_ack && p1_ack) both_ack = 1'b1;
            if (p0_ack) begin
                order[n_grants] = 1'b0;
                n_grants++;
            end else if (p1_ack) begin
                order[n_grants] = 1'b1;
                n_grants++;
            end
        end
        check("cont_grants", 32'(n_grants), 32'h6);
        check("cont_both",   32'(both_ack), 32'h0);
        for (int i = 0; i < 6; i++)
            check($sformatf("cont_order%0d", i), 32'(order[i]),
                  RR ? 32'(i % 2) : 32'h0);
        p0_req = 1'b0;
        p1_req = 1'b0;
        cyc(8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
